// File: rtl/mem_responder_if.sv
// Request/response bus between a memory initiator and mem_responder.
// The initiator drives valid/address/write data; the memory returns ready pulses and read data.
interface mem_responder_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
);
  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;
  logic                 mem_write_valid;
  logic [ADDR_BITS-1:0] mem_write_address;
  logic [DATA_BITS-1:0] mem_write_data;
  logic                 mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready
  );
endinterface

// File: rtl/mem_responder.sv
// Latency-configurable single-port data memory answering one read or write at a time.
// Define MEM_RANDOM_STALL_EN to add 0..3 LFSR-chosen stall cycles to every request.
module mem_responder #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 2
) (
  input  logic          clk,
  input  logic          reset,
  mem_responder_if.slave bus,
  output logic [15:0]   read_count,
  output logic [15:0]   write_count
);
  localparam int DEPTH    = 2 ** ADDR_BITS;
  localparam int CNT_BITS = 5;  // 15 cycles of latency plus up to 3 stall cycles

  typedef enum logic [1:0] {IDLE, BUSY, RESP, WAIT_DROP} state_t;
  typedef enum logic {OP_READ, OP_WRITE} op_t;

  state_t               state, state_next;
  op_t                  op_q;
  logic [CNT_BITS-1:0]  cnt_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] wdata_q;
  logic [DATA_BITS-1:0] read_data_q;
  logic                 read_ready_q;
  logic                 write_ready_q;
  logic [DATA_BITS-1:0] mem [DEPTH];

  logic [CNT_BITS-1:0]  extra;
  logic                 done;
  logic                 served_valid;

`ifdef MEM_RANDOM_STALL_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR, taps 8,6,5,4; free-running so stalls vary request to request.
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 8'hA5;
    else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign extra = CNT_BITS'(lfsr_q[1:0]);
`else
  assign extra = '0;
`endif

  assign done         = (state == BUSY) && (cnt_q == CNT_BITS'(1));
  assign served_valid = (op_q == OP_READ) ? bus.mem_read_valid : bus.mem_write_valid;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: default first, so no path through the case can infer a latch.
    state_next = state;
    case (state)
      IDLE:      if (bus.mem_read_valid || bus.mem_write_valid) state_next = BUSY;
      BUSY:      if (cnt_q == CNT_BITS'(1)) state_next = RESP;
      RESP:      state_next = WAIT_DROP;
      WAIT_DROP: if (!served_valid) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q          <= OP_READ;
      cnt_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      read_data_q   <= '0;
      read_ready_q  <= 1'b0;
      write_ready_q <= 1'b0;
      read_count    <= '0;
      write_count   <= '0;
    end else begin
      // NOTE: non-blocking throughout; every register sees pre-edge values of the others.
      read_ready_q  <= 1'b0;
      write_ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mem_read_valid) begin
            op_q   <= OP_READ;
            addr_q <= bus.mem_read_address;
            cnt_q  <= CNT_BITS'(READ_LATENCY) + extra;
          end else if (bus.mem_write_valid) begin
            op_q    <= OP_WRITE;
            addr_q  <= bus.mem_write_address;
            wdata_q <= bus.mem_write_data;
            cnt_q   <= CNT_BITS'(WRITE_LATENCY) + extra;
          end
        end
        BUSY: begin
          if (cnt_q == CNT_BITS'(1)) begin
            if (op_q == OP_READ) begin
              read_data_q  <= mem[addr_q];
              read_ready_q <= 1'b1;
              read_count   <= read_count + 16'd1;
            end else begin
              write_ready_q <= 1'b1;
              write_count   <= write_count + 16'd1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the array is reset on purpose so a reset leaves a known all-zero memory image;
  // this rules out inference as a block RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (done && op_q == OP_WRITE) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign bus.mem_read_ready  = read_ready_q;
  assign bus.mem_read_data   = read_data_q;
  assign bus.mem_write_ready = write_ready_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: latency, priority, handshake, abort and reset behaviour.
// With MEM_RANDOM_STALL_EN defined it runs the reset and random-stall scenarios.
module tb_mem_responder;
  logic        clk;
  logic        reset;
  logic [15:0] read_count;
  logic [15:0] write_count;
  int          errors = 0;
  int          checks = 0;

  mem_responder_if #(.ADDR_BITS(8), .DATA_BITS(16)) bus ();

  mem_responder #(
    .ADDR_BITS(8), .DATA_BITS(16), .READ_LATENCY(2), .WRITE_LATENCY(2)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .read_count(read_count), .write_count(write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] req_extra = 2'd0;
`ifdef MEM_RANDOM_STALL_EN
  logic [7:0] lfsr_m;
  always @(posedge clk) begin
    if (reset) lfsr_m <= 8'hA5;
    else       lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end
`endif

  // mode 0: plain; 1: change address/data after acceptance; 2: drop valid after acceptance.
  task automatic issue(input bit wr, input logic [7:0] a, input logic [15:0] d, input int mode,
                       output int lat, output logic [15:0] rd, output logic after,
                       output logic other);
    @(negedge clk);
    if (wr) begin
      bus.mem_write_address = a; bus.mem_write_data = d; bus.mem_write_valid = 1'b1;
    end else begin
      bus.mem_read_address = a; bus.mem_read_valid = 1'b1;
    end
`ifdef MEM_RANDOM_STALL_EN
    req_extra = lfsr_m[1:0];
`endif
    lat = -1; other = 1'b0; after = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if ((wr ? bus.mem_read_ready : bus.mem_write_ready) === 1'b1) other = 1'b1;
      if ((wr ? bus.mem_write_ready : bus.mem_read_ready) === 1'b1) begin
        lat = k - 1;
        break;
      end
      if (k == 1 && mode == 1) begin
        bus.mem_read_address  = a ^ 8'h01;
        bus.mem_write_address = a ^ 8'h01;
        bus.mem_write_data    = ~d;
      end
      if (k == 1 && mode == 2) begin
        bus.mem_read_valid = 1'b0; bus.mem_write_valid = 1'b0;
      end
    end
    rd = bus.mem_read_data;
    bus.mem_read_valid = 1'b0; bus.mem_write_valid = 1'b0;
    @(negedge clk);
    after = wr ? bus.mem_write_ready : bus.mem_read_ready;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.mem_read_ready !== 1'b0) begin errors++; $display("FAIL reset_rready: got %b want 0", bus.mem_read_ready); end
    checks++; if (bus.mem_write_ready !== 1'b0) begin errors++; $display("FAIL reset_wready: got %b want 0", bus.mem_write_ready); end
    checks++; if (bus.mem_read_data !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h want 0000", bus.mem_read_data); end
    checks++; if (read_count !== 16'd0) begin errors++; $display("FAIL reset_rcount: got %0d want 0", read_count); end
    checks++; if (write_count !== 16'd0) begin errors++; $display("FAIL reset_wcount: got %0d want 0", write_count); end
    reset = 1'b0;
  endtask

  task automatic test_read_basic();
    int lat; logic [15:0] rd; logic after, other;
    issue(1'b0, 8'h10, 16'h0, 0, lat, rd, after, other);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency: got %0d want 2", lat); end
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL rd_data: got %h want 0000", rd); end
    checks++; if (after !== 1'b0) begin errors++; $display("FAIL rd_pulse_width: ready next cycle %b want 0", after); end
    checks++; if (other !== 1'b0) begin errors++; $display("FAIL rd_no_wready: got %b want 0", other); end
    checks++; if (read_count !== 16'd1) begin errors++; $display("FAIL rd_count: got %0d want 1", read_count); end
  endtask

  task automatic test_write_read();
    int lat; logic [15:0] rd; logic after, other;
    issue(1'b1, 8'h3C, 16'hBEEF, 0, lat, rd, after, other);
    checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", lat); end
    checks++; if (after !== 1'b0) begin errors++; $display("FAIL wr_pulse_width: ready next cycle %b want 0", after); end
    checks++; if (other !== 1'b0) begin errors++; $display("FAIL wr_no_rready: got %b want 0", other); end
    checks++; if (write_count !== 16'd1) begin errors++; $display("FAIL wr_count: got %0d want 1", write_count); end
    issue(1'b0, 8'h3C, 16'h0, 0, lat, rd, after, other);
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL wr_readback: got %h want beef", rd); end
    checks++; if (read_count !== 16'd2) begin errors++; $display("FAIL wr_rcount: got %0d want 2", read_count); end
  endtask

  task automatic test_collision();
    int lat = -1, gap = -1; logic [15:0] rd; logic after, other, rr, wr_seen;
    logic rr_late = 1'b0;
    @(negedge clk);
    bus.mem_read_address = 8'h3C; bus.mem_read_valid = 1'b1;
    bus.mem_write_address = 8'h3C; bus.mem_write_data = 16'h1234; bus.mem_write_valid = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.mem_read_ready === 1'b1 || bus.mem_write_ready === 1'b1) begin lat = k - 1; break; end
    end
    rr = bus.mem_read_ready; wr_seen = bus.mem_write_ready; rd = bus.mem_read_data;
    bus.mem_read_valid = 1'b0;
    checks++; if (lat !== 2) begin errors++; $display("FAIL col_latency: got %0d want 2", lat); end
    checks++; if (rr !== 1'b1 || wr_seen !== 1'b0) begin errors++; $display("FAIL col_priority: rready=%b wready=%b want 1/0", rr, wr_seen); end
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL col_old_data: got %h want beef", rd); end
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (bus.mem_read_ready === 1'b1) rr_late = 1'b1;
      if (bus.mem_write_ready === 1'b1) begin gap = j; break; end
    end
    bus.mem_write_valid = 1'b0;
    checks++; if (gap !== 5) begin errors++; $display("FAIL col_write_spacing: got %0d want 5", gap); end
    checks++; if (rr_late !== 1'b0) begin errors++; $display("FAIL col_extra_rready: got %b want 0", rr_late); end
    repeat (2) @(negedge clk);
    checks++; if (write_count !== 16'd2) begin errors++; $display("FAIL col_wcount: got %0d want 2", write_count); end
    issue(1'b0, 8'h3C, 16'h0, 0, lat, rd, after, other);
    checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL col_reread: got %h want 1234", rd); end
    checks++; if (read_count !== 16'd4) begin errors++; $display("FAIL col_rcount: got %0d want 4", read_count); end
  endtask

  task automatic test_hold_valid();
    int lat = -1, pulses = 0; logic [15:0] rd; logic after, other;
    @(negedge clk);
    bus.mem_read_address = 8'h10; bus.mem_read_valid = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.mem_read_ready === 1'b1) begin lat = k - 1; break; end
    end
    checks++; if (lat !== 2) begin errors++; $display("FAIL hold_latency: got %0d want 2", lat); end
    repeat (3) begin
      @(negedge clk);
      if (bus.mem_read_ready === 1'b1) pulses++;
    end
    bus.mem_read_valid = 1'b0;
    checks++; if (pulses !== 0) begin errors++; $display("FAIL hold_second_pulse: got %0d pulses want 0", pulses); end
    checks++; if (read_count !== 16'd5) begin errors++; $display("FAIL hold_rcount: got %0d want 5", read_count); end
    issue(1'b0, 8'h3C, 16'h0, 0, lat, rd, after, other);
    checks++; if (lat !== 2) begin errors++; $display("FAIL hold_next_latency: got %0d want 2", lat); end
    checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL hold_next_data: got %h want 1234", rd); end
  endtask

  task automatic test_busy_changes();
    int lat; logic [15:0] rd; logic after, other;
    issue(1'b1, 8'h20, 16'hA1A1, 1, lat, rd, after, other);
    checks++; if (lat !== 2) begin errors++; $display("FAIL chg_wr_latency: got %0d want 2", lat); end
    issue(1'b0, 8'h20, 16'h0, 0, lat, rd, after, other);
    checks++; if (rd !== 16'hA1A1) begin errors++; $display("FAIL chg_captured: got %h want a1a1", rd); end
    issue(1'b0, 8'h21, 16'h0, 2, lat, rd, after, other);
    checks++; if (lat !== 2) begin errors++; $display("FAIL abort_latency: got %0d want 2", lat); end
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL chg_ignored: got %h want 0000", rd); end
    issue(1'b0, 8'h20, 16'h0, 0, lat, rd, after, other);
    checks++; if (lat !== 2) begin errors++; $display("FAIL abort_next_latency: got %0d want 2", lat); end
    checks++; if (read_count !== 16'd9 || write_count !== 16'd3) begin
      errors++; $display("FAIL chg_counts: got %0d/%0d want 9/3", read_count, write_count);
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic [15:0] rd; logic after, other;
    logic wr_seen = 1'b0;
    @(negedge clk);
    bus.mem_write_address = 8'h07; bus.mem_write_data = 16'h5555; bus.mem_write_valid = 1'b1;
    @(negedge clk);
    reset = 1'b1; bus.mem_write_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.mem_write_ready === 1'b1) wr_seen = 1'b1;
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.mem_write_ready === 1'b1) wr_seen = 1'b1;
    end
    checks++; if (wr_seen !== 1'b0) begin errors++; $display("FAIL abort_wready: got %b want 0", wr_seen); end
    checks++; if (read_count !== 16'd0 || write_count !== 16'd0) begin
      errors++; $display("FAIL abort_counts: got %0d/%0d want 0/0", read_count, write_count);
    end
    issue(1'b0, 8'h07, 16'h0, 0, lat, rd, after, other);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL abort_not_committed: got %h want 0000", rd); end
    issue(1'b0, 8'h3C, 16'h0, 0, lat, rd, after, other);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL abort_mem_cleared: got %h want 0000", rd); end
    checks++; if (read_count !== 16'd2 || write_count !== 16'd0) begin
      errors++; $display("FAIL abort_recount: got %0d/%0d want 2/0", read_count, write_count);
    end
  endtask

`ifdef MEM_RANDOM_STALL_EN
  task automatic test_random_stall();
    int lat; logic [15:0] rd; logic after, other;
    for (int i = 0; i < 100; i++) begin
      issue(1'b0, 8'h00, 16'h0, 0, lat, rd, after, other);
      checks++;
      if (lat !== 2 + int'(req_extra) || lat < 2 || lat > 5) begin
        errors++; $display("FAIL stall_latency[%0d]: got %0d want %0d", i, lat, 2 + int'(req_extra));
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.mem_read_valid = 1'b0; bus.mem_read_address = '0;
    bus.mem_write_valid = 1'b0; bus.mem_write_address = '0; bus.mem_write_data = '0;
    test_reset();
`ifdef MEM_RANDOM_STALL_EN
    test_random_stall();
`else
    test_read_basic();
    test_write_read();
    test_collision();
    test_hold_valid();
    test_busy_changes();
    test_reset_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end
endmodule
